// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box ROM, GF(2^8) helpers, FSM encodings and the
// legal (Nk, Nr) key-size check used by the iterative cipher cores.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } enc_state_e;

   // Forward S-box, byte 0x00 in the leftmost position
   localparam logic [0:2047] SBOX_ROM = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_ROM[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   function automatic bit legal_nk_nr(input int nk, input int nr);
      return ((nk == 4) && (nr == 10)) ||
             ((nk == 6) && (nr == 12)) ||
             ((nk == 8) && (nr == 14));
   endfunction

endpackage

// File: rtl/enc_round.sv
// One forward AES round on FIPS-197 ordered vectors (byte i = bits 8i..8i+7,
// column-major). MixColumns is skipped on the final round.
module enc_round
   import aes_pkg::*;
(
   input  logic [0:127] state_in,
   input  logic [0:127] round_key,
   input  logic         last,
   output logic [0:127] state_out
);

   logic [0:127] sb_s;
   logic [0:127] sr_s;
   logic [0:127] mc_s;
   logic [7:0]   a0_s;
   logic [7:0]   a1_s;
   logic [7:0]   a2_s;
   logic [7:0]   a3_s;

   // SubBytes -> ShiftRows -> MixColumns/bypass -> AddRoundKey
   always_comb begin
      sb_s      = '0;
      sr_s      = '0;
      mc_s      = '0;
      a0_s      = 8'h00;
      a1_s      = 8'h00;
      a2_s      = 8'h00;
      a3_s      = 8'h00;
      state_out = '0;
      for (int i = 0; i < 16; i++) begin
         sb_s[8*i +: 8] = sbox(state_in[8*i +: 8]);
      end
      // row r of column c takes row r of column (c + r) mod 4
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_s[8*(r + 4*c) +: 8] = sb_s[8*(r + 4*((c + r) % 4)) +: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0_s = sr_s[32*c      +: 8];
         a1_s = sr_s[32*c + 8  +: 8];
         a2_s = sr_s[32*c + 16 +: 8];
         a3_s = sr_s[32*c + 24 +: 8];
         mc_s[32*c      +: 8] = xtime(a0_s) ^ gf_mul3(a1_s) ^ a2_s ^ a3_s;
         mc_s[32*c + 8  +: 8] = a0_s ^ xtime(a1_s) ^ gf_mul3(a2_s) ^ a3_s;
         mc_s[32*c + 16 +: 8] = a0_s ^ a1_s ^ xtime(a2_s) ^ gf_mul3(a3_s);
         mc_s[32*c + 24 +: 8] = gf_mul3(a0_s) ^ a1_s ^ a2_s ^ xtime(a3_s);
      end
      if (last) begin
         state_out = sr_s ^ round_key;
      end else begin
         state_out = mc_s ^ round_key;
      end
   end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES forward cipher: initial AddRoundKey on accept, then one round
// per clock with round keys fetched by index from an external key store.
module aes_encrypt_iter
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_block,
   output logic [3:0]   rk_idx,
   input  logic [0:127] round_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_block,
   output logic         busy
);

   localparam logic [3:0] NR_L = 4'(Nr);

   if (!legal_nk_nr(Nk, Nr)) begin : g_illegal_key_cfg
      $error("aes_encrypt_iter: illegal (Nk, Nr) = (%0d, %0d)", Nk, Nr);
   end

   enc_state_e   fsm_r;
   enc_state_e   fsm_nxt_s;
   logic [0:127] state_r;
   logic [0:127] state_nxt_s;
   logic [0:127] round_out_s;
   logic [3:0]   rnd_r;
   logic [3:0]   rnd_nxt_s;
   logic         last_round_s;
   logic         in_ready_r;
   logic         out_valid_r;
   logic         busy_r;
   logic [3:0]   rk_idx_r;

   assign last_round_s = (rnd_r == NR_L);

   enc_round u_enc_round (
      .state_in  (state_r),
      .round_key (round_key),
      .last      (last_round_s),
      .state_out (round_out_s)
   );

   // Next-state, datapath and round-counter selection
   always_comb begin
      fsm_nxt_s   = fsm_r;
      state_nxt_s = state_r;
      rnd_nxt_s   = rnd_r;
      case (fsm_r)
         ST_IDLE: begin
            if (in_valid && in_ready_r) begin
               state_nxt_s = in_block ^ round_key;
               rnd_nxt_s   = 4'd1;
               fsm_nxt_s   = ST_RUN;
            end else begin
               fsm_nxt_s   = ST_IDLE;
            end
         end
         ST_RUN: begin
            state_nxt_s = round_out_s;
            if (last_round_s) begin
               rnd_nxt_s = 4'd0;
               fsm_nxt_s = ST_DONE;
            end else begin
               rnd_nxt_s = rnd_r + 4'd1;
               fsm_nxt_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               fsm_nxt_s = ST_IDLE;
            end else begin
               fsm_nxt_s = ST_DONE;
            end
         end
         default: begin
            fsm_nxt_s   = ST_IDLE;
            state_nxt_s = '0;
            rnd_nxt_s   = 4'd0;
         end
      endcase
   end

   // State register; handshake outputs are registered decodes of the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_r       <= ST_IDLE;
         state_r     <= '0;
         rnd_r       <= 4'd0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         rk_idx_r    <= 4'd0;
      end else begin
         fsm_r       <= fsm_nxt_s;
         state_r     <= state_nxt_s;
         rnd_r       <= rnd_nxt_s;
         in_ready_r  <= (fsm_nxt_s == ST_IDLE);
         out_valid_r <= (fsm_nxt_s == ST_DONE);
         busy_r      <= (fsm_nxt_s != ST_IDLE);
         rk_idx_r    <= (fsm_nxt_s == ST_RUN) ? rnd_nxt_s : 4'd0;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign rk_idx    = rk_idx_r;
   assign out_block = state_r;

`ifdef AES_ENC_ITER_DEBUG
   // Round-by-round trace for bring-up
   always_ff @(posedge clk) begin
      if (rst_n && (fsm_r == ST_RUN)) begin
         $display("aes_encrypt_iter: rnd %0d state %h", rnd_r, round_out_s);
      end
   end
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed and random checks of aes_encrypt_iter against FIPS-197 vectors and
// an independent reference cipher with an algebraically derived S-box.
module tb_aes_encrypt_iter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [0:127] in_block;
   logic         in_valid_a, in_valid_b, out_ready;
   logic         in_ready_a, in_ready_b, out_valid_a, out_valid_b, busy_a, busy_b;
   logic [3:0]   rk_idx_a, rk_idx_b;
   logic [0:127] round_key_a, round_key_b, out_block_a, out_block_b;
   logic [0:127] ks_a [16];
   logic [0:127] ks_b [16];
   logic [7:0]   tb_sbox [256];
   logic [0:127] exp_q [$];
   logic         sel;
   logic         obs_valid, obs_ready, obs_busy;
   logic [0:127] obs_block;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           send_cyc = 0;

   always #5 clk = ~clk;

   aes_encrypt_iter #(.Nk(4), .Nr(10)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_block(in_block), .rk_idx(rk_idx_a), .round_key(round_key_a),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_block(out_block_a),
      .busy(busy_a));

   aes_encrypt_iter #(.Nk(8), .Nr(14)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_block(in_block), .rk_idx(rk_idx_b), .round_key(round_key_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_block(out_block_b),
      .busy(busy_b));

   assign round_key_a = ks_a[rk_idx_a];
   assign round_key_b = ks_b[rk_idx_b];
   assign obs_valid   = sel ? out_valid_b : out_valid_a;
   assign obs_ready   = sel ? in_ready_b  : in_ready_a;
   assign obs_busy    = sel ? busy_b      : busy_a;
   assign obs_block   = sel ? out_block_b : out_block_a;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
   endfunction

   function automatic logic [0:127] round_key_of(input logic [0:255] key, input int nk, input int r);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0]  rc;
      for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
      for (int i = nk; i < 4*(r+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            rc = 8'h01;
            for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
         end else if ((nk > 6) && (i % nk == 4)) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [0:127] ref_enc(input logic [0:127] pt, input logic [0:255] key,
                                            input int nk, input int nr);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [0:127] rk;
      logic [0:127] res;
      rk = round_key_of(key, nk, 0);
      for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk[8*i +: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
         if (r != nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         rk = round_key_of(key, nk, r);
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[8*i +: 8];
      end
      for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
      return res;
   endfunction

   task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_n(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic load_keys(input logic [0:255] key, input int nk, input int nr, input logic b);
      for (int r = 0; r <= nr; r++) begin
         if (b) ks_b[r] = round_key_of(key, nk, r);
         else   ks_a[r] = round_key_of(key, nk, r);
      end
   endtask

   task automatic send(input logic [0:127] blk, input logic [0:127] exp);
      chk_b("in_ready_idle", obs_ready, 1'b1);
      in_block = blk;
      if (sel) in_valid_b = 1'b1;
      else     in_valid_a = 1'b1;
      exp_q.push_back(exp);
      send_cyc = cyc;
      step();
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      in_block   = {$urandom(), $urandom(), $urandom(), $urandom()};
      chk_b("busy_running", obs_busy, 1'b1);
   endtask

   task automatic wait_out(input int bound, output int lat);
      int n = 0;
      while (!obs_valid && n < bound) begin
         step();
         n++;
      end
      chk_b("out_valid_timeout", obs_valid, 1'b1);
      lat = cyc - send_cyc;
   endtask

   task automatic take();
      logic [0:127] e = '0;
      if (exp_q.size() == 0) chk_n("scoreboard_empty", 0, 1);
      else e = exp_q.pop_front();
      chk_w("out_block", obs_block, e);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_b("out_valid_drop", obs_valid, 1'b0);
      chk_b("in_ready_after", obs_ready, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:255] key_b_app, key_c1, key_c3;
      logic [0:127] pt_c, pt, held;
      logic [7:0]   inv, x;
      logic         seen;
      int           lat, stall, prev_cyc, prev_stall;

      in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready = 1'b0; in_block = '0; sel = 1'b0;
      for (int i = 0; i < 16; i++) begin ks_a[i] = '0; ks_b[i] = '0; end
      for (int v = 0; v < 256; v++) begin
         x   = 8'(v);
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
         tb_sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      key_b_app = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
      key_c1    = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      key_c3    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      pt_c      = 128'h00112233445566778899aabbccddeeff;

      // Reset values
      load_keys(key_b_app, 4, 10, 1'b0);
      repeat (3) step();
      chk_b("rst_in_ready", in_ready_a, 1'b0);
      chk_b("rst_out_valid", out_valid_a, 1'b0);
      chk_w("rst_out_block", out_block_a, 128'h0);
      chk_n("rst_rk_idx", int'(rk_idx_a), 0);
      chk_b("rst_busy", busy_a, 1'b0);
      rst_n = 1'b1;
      step();
      chk_b("rel_in_ready_a", in_ready_a, 1'b1);
      chk_b("rel_in_ready_b", in_ready_b, 1'b1);

      // FIPS-197 App. B
      send(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
      wait_out(40, lat);
      chk_n("lat_app_b", lat, 11);
      take();

      // App. C.1 with round-key index sequence
      load_keys(key_c1, 4, 10, 1'b0);
      chk_n("rk_idx_0", int'(rk_idx_a), 0);
      send(pt_c, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk_n("rk_idx_1", int'(rk_idx_a), 1);
      for (int k = 2; k <= 10; k++) begin
         step();
         chk_n("rk_idx_seq", int'(rk_idx_a), k);
      end
      wait_out(40, lat);
      chk_n("lat_c1", lat, 11);
      chk_n("rk_idx_done", int'(rk_idx_a), 0);
      take();

      // Back-pressure in DONE with ignored in_valid pulses
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt, ref_enc(pt, key_c1, 4, 10));
      wait_out(40, lat);
      held = out_block_a;
      for (int k = 0; k < 20; k++) begin
         in_valid_a = k[0];
         in_block   = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
         chk_w("bp_block_held", out_block_a, held);
         chk_b("bp_in_ready", in_ready_a, 1'b0);
         chk_b("bp_out_valid", out_valid_a, 1'b1);
      end
      in_valid_a = 1'b0;
      take();
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt, ref_enc(pt, key_c1, 4, 10));
      wait_out(40, lat);
      take();

      // Reset while at round 5
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt, ref_enc(pt, key_c1, 4, 10));
      repeat (4) step();
      chk_n("rk_idx_round5", int'(rk_idx_a), 5);
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      step();
      chk_b("mid_rst_in_ready", in_ready_a, 1'b0);
      chk_b("mid_rst_out_valid", out_valid_a, 1'b0);
      chk_w("mid_rst_out_block", out_block_a, 128'h0);
      chk_n("mid_rst_rk_idx", int'(rk_idx_a), 0);
      chk_b("mid_rst_busy", busy_a, 1'b0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         seen = seen | out_valid_a;
         step();
      end
      chk_b("no_out_after_rst", seen, 1'b0);
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt, ref_enc(pt, key_c1, 4, 10));
      wait_out(40, lat);
      take();

      // AES-256, App. C.3
      sel = 1'b1;
      load_keys(key_c3, 8, 14, 1'b1);
      send(pt_c, 128'h8ea2b7ca516745bfeafc49904b496089);
      wait_out(40, lat);
      chk_n("lat_c3", lat, 15);
      take();
      sel = 1'b0;

      // Back-to-back random blocks with random output stalls
      load_keys(key_b_app, 4, 10, 1'b0);
      prev_cyc = 0;
      prev_stall = 0;
      for (int i = 0; i < 8; i++) begin
         pt = {$urandom(), $urandom(), $urandom(), $urandom()};
         send(pt, ref_enc(pt, key_b_app, 4, 10));
         if (i > 0) chk_n("b2b_period", send_cyc - prev_cyc, 12 + prev_stall);
         prev_cyc = send_cyc;
         wait_out(40, lat);
         chk_n("b2b_latency", lat, 11);
         stall = $urandom_range(0, 3);
         repeat (stall) step();
         prev_stall = stall;
         take();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative AES forward cipher core, the encryption counterpart of the inverse-round datapath. It accepts one 128-bit plaintext block over a valid/ready handshake and executes the initial AddRoundKey plus Nr forward rounds, one round per clock. It pulls round keys from an external key schedule by index and presents the ciphertext over a valid/ready output handshake. It sits between the block-mode controller and the key-expansion store, on the encrypt path.

## Interface
- Nk, 4, key length in 32-bit words (4/6/8)
- Nr, 10, number of rounds; legal pairs only: (4,10), (6,12), (8,14)
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  in_block valid
- in_ready  out  1  core idle, can accept a block
- in_block  in  [0:127]  plaintext, FIPS-197 byte order (byte 0 = bits 0:7, column-major)
- rk_idx  out  4  round-key index requested this cycle (0..Nr)
- round_key  in  [0:127]  round key rk_idx, combinational from key store, same cycle
- out_valid  out  1  out_block holds ciphertext
- out_ready  in  1  consumer accepts out_block
- out_block  out  [0:127]  ciphertext
- busy  out  1  block in flight or output pending

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, rk_idx=0. On in_valid&in_ready, state_q <= in_block ^ round_key, rnd <= 1, go to RUN.
- RUN: rk_idx=rnd. Each cycle, state_q <= enc_round(state_q, round_key, last=(rnd==Nr)).
  - Non-last round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Last round: SubBytes, ShiftRows, AddRoundKey; MixColumns is bypassed.
  - rnd increments. When rnd==Nr, go to DONE.
- DONE: out_valid=1, out_block=state_q, rk_idx=0. On out_ready, go to IDLE. out_block is held stable while out_ready=0.
- in_valid is ignored outside IDLE; in_block is sampled only at the accept edge.
- round_key is sampled only on edges in IDLE-accept and RUN; its value elsewhere is don't-care.
- rnd is 4 bits wide, never exceeds Nr, and never wraps.
- Reset, including mid-RUN or in DONE: FSM=IDLE, state_q=0, rnd=0. The in-flight block is discarded and no out_valid pulse is produced.
- Reset values: in_ready=0 while rst_n=0 and 1 on the first cycle after release; out_valid=0; out_block=0; rk_idx=0; busy=0.

## Timing
- Accept edge is E0. Round r is applied at edge Er, for r=1..Nr.
- out_valid goes high in the cycle after E(Nr): latency is Nr+1 cycles from in_valid sampled to out_valid. For Nr=10 that is 11 cycles.
- An out_ready already high when out_valid rises completes the transfer at that edge. in_ready is 1 the following cycle.
- Minimum block period: Nr+2 cycles. There is no overlap of input and output.
- busy = (FSM != IDLE).
- rk_idx is a registered-state decode only, with no combinational path from any input. round_key must settle in the same cycle.
- Back-pressure of any length in DONE is legal; the data is held.

## Structure
- Shared package/header aes_pkg: S-box ROM function, xtime/GF(2^8) multiply, FSM state encodings, and the legal (Nk, Nr) check. An elaboration error is raised on an illegal pair.
- Sub-module enc_round: combinational SubBytes→ShiftRows→MixColumns (bypass on `last`)→AddRoundKey, on [0:127] vectors.
  - Reuses the existing AddRoundKey and shift-row conventions.
  - One instance only; the top module holds the FSM, the rnd counter, state_q and the handshakes.
- Debug $display output is gated behind a define and is off by default.

## Test plan
- AES-128, FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → out_block 3925841d02dc09fbdc118597196a0b32. out_valid rises exactly 11 cycles after accept.
- AES-128, App. C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. rk_idx sequence is 0,1,…,10 on successive cycles.
- AES-256 (Nk=8, Nr=14), App. C.3: key 000102…1f, same pt → 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE → out_block stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready → in_ready=1 on the next cycle, then accept the next block.
- Reset at round 5 → out_valid never asserts for that block and all outputs hold their reset values. A block issued after release returns the correct ciphertext.
- Back-to-back: 8 random blocks with random out_ready stalls → every output matches the reference model in order, and each block period is at least Nr+2 cycles.
